ysyx_22040127_lsu: RTL and testbench
====================================

// Module: ysyx_22040127_lsu
// PURPOSE
//  Multicycle RV64 load/store unit between EX and WB. Takes one memory op per transaction
//  (addr, store data, op code) and issues one 8-byte-aligned request on the data-memory bus
//  (wmask, lane-shifted wdata). On loads it extracts and sign/zero-extends the addressed
//  lane(s) from the response. It flags misaligned and timed-out accesses and returns one result.
// PARAMETERS
//  XLEN        64   data/address width; only 64 is supported
//  TIMEOUT     255  max cycles spent in REQ+WAIT before erroring out; 0 disables the timeout
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     EX presents an op
//  in_ready     out  1     LSU can accept (IDLE only)
//  in_op        in   4     {is_store, is_unsigned, size[1:0]}; size 0=B 1=H 2=W 3=D
//  in_addr      in   XLEN  byte address
//  in_wdata     in   XLEN  store data, right-aligned
//  out_valid    out  1     result available to WB
//  out_ready    in   1     WB accepts
//  out_rdata    out  XLEN  extended load data; 0 for stores and errors
//  out_misalign out  1     addr not aligned to size; no bus access was made
//  out_timeout  out  1     bus did not complete within TIMEOUT cycles
//  req_valid    out  1     bus request
//  req_ready    in   1     bus accepts request
//  req_we       out  1     1 = write
//  req_addr     out  XLEN  {in_addr[63:3], 3'b0}
//  req_wdata    out  XLEN  store data shifted left by 8*addr[2:0]
//  req_wmask    out  8     byte enables; 0 on reads
//  resp_valid   in   1     read data / write ack, one cycle, at most one per request
//  resp_rdata   in   XLEN  aligned doubleword
// BEHAVIOUR
//  Reset: state=IDLE. in_ready=1. out_valid=0, req_valid=0. out_rdata, flags, req_* = 0. Timeout counter=0.
//  FSM: IDLE -> REQ -> WAIT -> DONE -> IDLE.
//   IDLE: in_ready=1; on in_valid, latch op/addr/wdata. Aligned -> REQ; misaligned -> DONE with out_misalign=1.
//   REQ : req_valid=1, req_* held stable until req_ready; on handshake -> WAIT.
//   WAIT: on resp_valid, latch extended data (loads) or 0 (stores) -> DONE.
//         resp_valid in the same cycle as the req handshake is ignored; the bus must not do this.
//   DONE: out_valid=1 and outputs held until out_ready -> IDLE. No new op is accepted in DONE (no bypass).
//  Latency, zero-wait bus: accept T, req_valid T+1 (req_ready=1), resp_valid T+2, out_valid T+3.
//   Misaligned: accept T, out_valid T+1.
//  Alignment: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
//  in_op[2] with size=3 is treated as ld. in_op[2] on a store is ignored.
//  wmask: B 8'b1<<a, H 8'b11<<a, W 8'hF<<a, D 8'hFF, where a=addr[2:0].
//  Load extract: lane = resp_rdata >> 8*a, truncated to size. Sign-extend unless is_unsigned.
//  Timeout: counter clears on entry to REQ and increments each REQ/WAIT cycle.
//   When it reaches TIMEOUT -> DONE with out_timeout=1, req_valid dropped, out_rdata=0.
//   A late resp_valid arriving in IDLE/DONE is ignored.
//  Reset mid-operation: return to IDLE next cycle and abandon any outstanding request.
//   The bus owner must also reset.
// STRUCTURE
//  Package ysyx_22040127_lsu_pkg: op-field localparams (OP_STORE, OP_UNSIGNED, SZ_B/H/W/D),
//   state enum, LSU_TIMEOUT default.
//  Sub-module ysyx_22040127_lsu_align: purely combinational. (size, addr[2:0], wdata, rdata, unsigned)
//   -> (wmask, shifted wdata, extended rdata, misalign). The FSM and timeout counter stay in the top.
// TESTING
//  1 lb addr=0x8000_0003, resp=0x1122_3344_8566_7788 -> out_rdata=0xFFFF_FFFF_FFFF_FF85, out_valid at T+3.
//  2 sh addr=0x8000_0006, wdata=0xBEEF -> req_addr=0x8000_0000, req_wmask=8'hC0,
//    req_wdata=0xBEEF_0000_0000_0000; ack gives out_rdata=0.
//  3 lw addr=0x8000_0002 -> no req_valid ever; out_misalign=1 at T+1; in_ready returns after out_ready.
//  4 lwu addr=0x4, req_ready low 3 cycles, resp 2 cycles later, out_ready low 2 cycles
//    -> req_* stable while stalled; out_rdata=0x0000_0000_8566_7788 held until out_ready.
//  5 TIMEOUT=4, ld with resp never arriving -> out_timeout=1 with out_rdata=0;
//    a later resp_valid is ignored; the next ld completes normally.
//  6 rst asserted during WAIT -> next cycle IDLE, in_ready=1, all outputs 0; a following sd gives wmask=8'hFF.

Source files
------------

// File: rtl/ysyx_22040127_lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ysyx_22040127_lsu_pkg : op-field encodings and FSM state for LSU  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package ysyx_22040127_lsu_pkg;

   localparam int OP_STORE    = 3;
   localparam int OP_UNSIGNED = 2;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam int LSU_TIMEOUT = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040127_lsu_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ysyx_22040127_lsu_if : data-memory request/response bus          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface ysyx_22040127_lsu_if #(
   parameter int XLEN = 64
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic [7:0]      req_wmask;
   logic            resp_valid;
   logic [XLEN-1:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wmask,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wmask,
      output req_ready, resp_valid, resp_rdata
   );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040127_lsu_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ysyx_22040127_lsu_align : byte-lane steering, masks, extension   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module ysyx_22040127_lsu_align
   import ysyx_22040127_lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [1:0]      size,
   input  logic [2:0]      off,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   input  logic            is_unsigned,
   output logic [7:0]      wmask,
   output logic [XLEN-1:0] wdata_sh,
   output logic [XLEN-1:0] rdata_ext,
   output logic            misalign
);
   logic [XLEN-1:0] w_lane;

   always_comb begin
      w_lane    = rdata >> {off, 3'b000};
      wdata_sh  = wdata << {off, 3'b000};
      wmask     = 8'h00;
      misalign  = 1'b0;
      rdata_ext = w_lane;
      case (size)
         SZ_B: begin
            wmask     = 8'h01 << off;
            rdata_ext = is_unsigned ? {{(XLEN-8){1'b0}}, w_lane[7:0]}
                                    : {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
         end
         SZ_H: begin
            misalign  = off[0];
            wmask     = 8'h03 << off;
            rdata_ext = is_unsigned ? {{(XLEN-16){1'b0}}, w_lane[15:0]}
                                    : {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
         end
         SZ_W: begin
            misalign  = |off[1:0];
            wmask     = 8'h0F << off;
            rdata_ext = is_unsigned ? {{(XLEN-32){1'b0}}, w_lane[31:0]}
                                    : {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
         end
         default: begin
            // Doubleword: unsigned flag is meaningless, behaves as ld
            misalign  = |off;
            wmask     = 8'hFF;
            rdata_ext = w_lane;
         end
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/ysyx_22040127_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ysyx_22040127_lsu : multicycle RV64 load/store unit (EX -> WB)   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module ysyx_22040127_lsu
   import ysyx_22040127_lsu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = LSU_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [XLEN-1:0]   in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_rdata,
   output logic              out_misalign,
   output logic              out_timeout,
   ysyx_22040127_lsu_if.master mem
);
   localparam int CNT_W = $clog2(TIMEOUT + 2);

   lsu_state_t       r_state;
   logic             r_in_ready;
   logic             r_out_valid, r_out_misalign, r_out_timeout;
   logic [XLEN-1:0]  r_out_rdata;
   logic             r_req_valid, r_req_we;
   logic [XLEN-1:0]  r_req_addr, r_req_wdata;
   logic [7:0]       r_req_wmask;
   logic [1:0]       r_size;
   logic [2:0]       r_off;
   logic             r_unsigned, r_is_store;
   logic [CNT_W-1:0] r_cnt;

   logic             w_idle, w_misalign, w_expire;
   logic [1:0]       w_size;
   logic [2:0]       w_off;
   logic             w_unsigned;
   logic [7:0]       w_wmask;
   logic [XLEN-1:0]  w_wdata_sh, w_rdata_ext;
   logic [CNT_W-1:0] w_cnt_nxt;

   // The lane unit sees the incoming op in IDLE and the latched op afterwards
   assign w_idle     = (r_state == ST_IDLE);
   assign w_size     = w_idle ? in_op[1:0] : r_size;
   assign w_off      = w_idle ? in_addr[2:0] : r_off;
   assign w_unsigned = w_idle ? in_op[OP_UNSIGNED] : r_unsigned;
   assign w_cnt_nxt  = r_cnt + 1'b1;
   assign w_expire   = (TIMEOUT != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT));

   ysyx_22040127_lsu_align #(.XLEN(XLEN)) u_align (
      .size        (w_size),
      .off         (w_off),
      .wdata       (in_wdata),
      .rdata       (mem.resp_rdata),
      .is_unsigned (w_unsigned),
      .wmask       (w_wmask),
      .wdata_sh    (w_wdata_sh),
      .rdata_ext   (w_rdata_ext),
      .misalign    (w_misalign)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_in_ready     <= 1'b1;
         r_out_valid    <= 1'b0;
         r_out_misalign <= 1'b0;
         r_out_timeout  <= 1'b0;
         r_out_rdata    <= '0;
         r_req_valid    <= 1'b0;
         r_req_we       <= 1'b0;
         r_req_addr     <= '0;
         r_req_wdata    <= '0;
         r_req_wmask    <= '0;
         r_size         <= '0;
         r_off          <= '0;
         r_unsigned     <= 1'b0;
         r_is_store     <= 1'b0;
         r_cnt          <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_size     <= in_op[1:0];
                  r_off      <= in_addr[2:0];
                  r_unsigned <= in_op[OP_UNSIGNED];
                  r_is_store <= in_op[OP_STORE];
                  r_in_ready <= 1'b0;
                  if (w_misalign) begin
                     r_state        <= ST_DONE;
                     r_out_valid    <= 1'b1;
                     r_out_misalign <= 1'b1;
                     r_out_rdata    <= '0;
                  end else begin
                     r_state     <= ST_REQ;
                     r_cnt       <= '0;
                     r_req_valid <= 1'b1;
                     r_req_we    <= in_op[OP_STORE];
                     r_req_addr  <= {in_addr[XLEN-1:3], 3'b000};
                     r_req_wdata <= in_op[OP_STORE] ? w_wdata_sh : '0;
                     r_req_wmask <= in_op[OP_STORE] ? w_wmask : 8'h00;
                  end
               end
            end
            ST_REQ: begin
               r_cnt <= w_cnt_nxt;
               if (w_expire || mem.req_ready) begin
                  r_req_valid <= 1'b0;
                  r_req_we    <= 1'b0;
                  r_req_addr  <= '0;
                  r_req_wdata <= '0;
                  r_req_wmask <= '0;
               end
               if (w_expire) begin
                  r_state       <= ST_DONE;
                  r_out_valid   <= 1'b1;
                  r_out_timeout <= 1'b1;
                  r_out_rdata   <= '0;
               end else if (mem.req_ready) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_cnt <= w_cnt_nxt;
               // A response on the expiry cycle still counts as completion
               if (mem.resp_valid) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
                  r_out_rdata <= r_is_store ? '0 : w_rdata_ext;
               end else if (w_expire) begin
                  r_state       <= ST_DONE;
                  r_out_valid   <= 1'b1;
                  r_out_timeout <= 1'b1;
                  r_out_rdata   <= '0;
               end
            end
            default: begin
               if (out_ready) begin
                  r_state        <= ST_IDLE;
                  r_in_ready     <= 1'b1;
                  r_out_valid    <= 1'b0;
                  r_out_misalign <= 1'b0;
                  r_out_timeout  <= 1'b0;
                  r_out_rdata    <= '0;
               end
            end
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign out_valid     = r_out_valid;
   assign out_rdata     = r_out_rdata;
   assign out_misalign  = r_out_misalign;
   assign out_timeout   = r_out_timeout;
   assign mem.req_valid = r_req_valid;
   assign mem.req_we    = r_req_we;
   assign mem.req_addr  = r_req_addr;
   assign mem.req_wdata = r_req_wdata;
   assign mem.req_wmask = r_req_wmask;
endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040127_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ysyx_22040127_lsu : directed self-checking bench for the LSU  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_ysyx_22040127_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, t_in_valid;
   logic        in_ready, t_in_ready;
   logic [3:0]  in_op;
   logic [63:0] in_addr, in_wdata;
   logic        out_ready;
   logic        out_valid, t_out_valid;
   logic [63:0] out_rdata, t_out_rdata;
   logic        out_misalign, t_out_misalign;
   logic        out_timeout, t_out_timeout;

   int n_cmp = 0;
   int n_err = 0;

   ysyx_22040127_lsu_if #(.XLEN(64)) bus ();
   ysyx_22040127_lsu_if #(.XLEN(64)) t_bus ();

   ysyx_22040127_lsu dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_misalign(out_misalign), .out_timeout(out_timeout),
      .mem(bus.master)
   );

   ysyx_22040127_lsu #(.XLEN(64), .TIMEOUT(4)) dut_to (
      .clk(clk), .rst(rst),
      .in_valid(t_in_valid), .in_ready(t_in_ready), .in_op(in_op),
      .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid(t_out_valid), .out_ready(out_ready), .out_rdata(t_out_rdata),
      .out_misalign(t_out_misalign), .out_timeout(t_out_timeout),
      .mem(t_bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (actual=running required=finished)");
      $fatal(1);
   end

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid, bus.req_valid, out_misalign, out_timeout} !== 5'b10000) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 10000",
                  {in_ready, out_valid, bus.req_valid, out_misalign, out_timeout});
      end
      n_cmp++;
      if ({out_rdata, bus.req_addr, bus.req_wdata, bus.req_wmask, bus.req_we} !== '0) begin
         n_err++;
         $display("FAIL reset_data: rdata=%h addr=%h wmask=%h want all 0",
                  out_rdata, bus.req_addr, bus.req_wmask);
      end
   endtask

   task automatic test_lb();
      @(negedge clk);
      in_valid = 1; in_op = 4'b0000; in_addr = 64'h8000_0003; bus.req_ready = 1;
      @(negedge clk);
      in_valid = 0;
      n_cmp++;
      if ({bus.req_valid, bus.req_we, bus.req_wmask, bus.req_addr} !== {2'b10, 8'h00, 64'h8000_0000}) begin
         n_err++;
         $display("FAIL lb_req: valid=%b we=%b wmask=%h addr=%h want 1 0 00 80000000",
                  bus.req_valid, bus.req_we, bus.req_wmask, bus.req_addr);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.req_valid, out_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL lb_wait: req_valid=%b out_valid=%b want 0 0", bus.req_valid, out_valid);
      end
      bus.resp_valid = 1; bus.resp_rdata = 64'h1122_3344_8566_7788;
      @(negedge clk);
      bus.resp_valid = 0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_rdata !== 64'hFFFF_FFFF_FFFF_FF85) begin
         n_err++;
         $display("FAIL lb_result: valid=%b rdata=%h want 1 ffffffffffffff85", out_valid, out_rdata);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL lb_retire: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_sh();
      @(negedge clk);
      in_valid = 1; in_op = 4'b1001; in_addr = 64'h8000_0006; in_wdata = 64'hBEEF;
      bus.req_ready = 1;
      @(negedge clk);
      in_valid = 0;
      n_cmp++;
      if ({bus.req_valid, bus.req_we, bus.req_wmask} !== {2'b11, 8'hC0} ||
          bus.req_addr !== 64'h8000_0000 || bus.req_wdata !== 64'hBEEF_0000_0000_0000) begin
         n_err++;
         $display("FAIL sh_req: valid=%b we=%b wmask=%h addr=%h wdata=%h want 1 1 c0 80000000 beef000000000000",
                  bus.req_valid, bus.req_we, bus.req_wmask, bus.req_addr, bus.req_wdata);
      end
      @(negedge clk);
      bus.resp_valid = 1; bus.resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      bus.resp_valid = 0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_rdata !== 64'h0) begin
         n_err++;
         $display("FAIL sh_ack: valid=%b rdata=%h want 1 0", out_valid, out_rdata);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
   endtask

   task automatic test_misalign();
      logic seen_req;
      seen_req = 0;
      @(negedge clk);
      in_valid = 1; in_op = 4'b0010; in_addr = 64'h8000_0002;
      @(negedge clk);
      // Keep offering an op: DONE must not accept it
      in_op = 4'b0011; in_addr = 64'h8000_0008;
      seen_req = bus.req_valid;
      n_cmp++;
      if ({out_valid, out_misalign, in_ready, out_rdata} !== {3'b110, 64'h0}) begin
         n_err++;
         $display("FAIL lw_misalign: valid=%b mis=%b in_ready=%b rdata=%h want 1 1 0 0",
                  out_valid, out_misalign, in_ready, out_rdata);
      end
      @(negedge clk);
      seen_req = seen_req | bus.req_valid;
      n_cmp++;
      if ({out_valid, out_misalign, in_ready} !== 3'b110) begin
         n_err++;
         $display("FAIL lw_hold: valid=%b mis=%b in_ready=%b want 1 1 0", out_valid, out_misalign, in_ready);
      end
      in_valid = 0;
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      seen_req = seen_req | bus.req_valid;
      n_cmp++;
      if ({out_valid, out_misalign, in_ready, seen_req} !== 4'b0010) begin
         n_err++;
         $display("FAIL lw_retire: valid=%b mis=%b in_ready=%b any_req=%b want 0 0 1 0",
                  out_valid, out_misalign, in_ready, seen_req);
      end
   endtask

   task automatic test_stall();
      @(negedge clk);
      in_valid = 1; in_op = 4'b0110; in_addr = 64'h4; bus.req_ready = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 0;
         n_cmp++;
         if ({bus.req_valid, bus.req_we, bus.req_wmask} !== 10'b10_0000_0000 || bus.req_addr !== 64'h0) begin
            n_err++;
            $display("FAIL lwu_stall%0d: valid=%b we=%b wmask=%h addr=%h want 1 0 00 0",
                     i, bus.req_valid, bus.req_we, bus.req_wmask, bus.req_addr);
         end
      end
      bus.req_ready = 1;
      @(negedge clk);
      bus.req_ready = 0;
      @(negedge clk);
      n_cmp++;
      if ({bus.req_valid, out_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL lwu_wait: req_valid=%b out_valid=%b want 0 0", bus.req_valid, out_valid);
      end
      bus.resp_valid = 1; bus.resp_rdata = 64'h8566_7788_DEAD_BEEF;
      @(negedge clk);
      bus.resp_valid = 0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) out_ready = 1;
         n_cmp++;
         if (out_valid !== 1'b1 || out_rdata !== 64'h0000_0000_8566_7788) begin
            n_err++;
            $display("FAIL lwu_hold%0d: valid=%b rdata=%h want 1 0000000085667788", i, out_valid, out_rdata);
         end
         @(negedge clk);
      end
      out_ready = 0;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL lwu_retire: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_timeout();
      int wait_cyc;
      @(negedge clk);
      t_in_valid = 1; in_op = 4'b0011; in_addr = 64'h8000_0008; t_bus.req_ready = 1;
      @(negedge clk);
      t_in_valid = 0;
      wait_cyc = 0;
      while (t_out_valid !== 1'b1 && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      n_cmp++;
      if (t_out_valid !== 1'b1 || t_out_timeout !== 1'b1 || t_out_rdata !== 64'h0 || t_bus.req_valid !== 1'b0) begin
         n_err++;
         $display("FAIL ld_timeout: valid=%b timeout=%b rdata=%h req_valid=%b want 1 1 0 0",
                  t_out_valid, t_out_timeout, t_out_rdata, t_bus.req_valid);
      end
      t_bus.resp_valid = 1; t_bus.resp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      @(negedge clk);
      t_bus.resp_valid = 0;
      n_cmp++;
      if (t_out_valid !== 1'b1 || t_out_timeout !== 1'b1 || t_out_rdata !== 64'h0) begin
         n_err++;
         $display("FAIL late_resp_done: valid=%b timeout=%b rdata=%h want 1 1 0",
                  t_out_valid, t_out_timeout, t_out_rdata);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      t_bus.resp_valid = 1;
      @(negedge clk);
      t_bus.resp_valid = 0;
      n_cmp++;
      if ({t_out_valid, t_out_timeout, t_in_ready} !== 3'b001) begin
         n_err++;
         $display("FAIL late_resp_idle: valid=%b timeout=%b in_ready=%b want 0 0 1",
                  t_out_valid, t_out_timeout, t_in_ready);
      end
      t_in_valid = 1; in_op = 4'b0011; in_addr = 64'h10;
      @(negedge clk);
      t_in_valid = 0;
      @(negedge clk);
      t_bus.resp_valid = 1; t_bus.resp_rdata = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      t_bus.resp_valid = 0;
      n_cmp++;
      if (t_out_valid !== 1'b1 || t_out_timeout !== 1'b0 || t_out_rdata !== 64'h0123_4567_89AB_CDEF) begin
         n_err++;
         $display("FAIL ld_after_timeout: valid=%b timeout=%b rdata=%h want 1 0 0123456789abcdef",
                  t_out_valid, t_out_timeout, t_out_rdata);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      in_valid = 1; in_op = 4'b0011; in_addr = 64'h8; bus.req_ready = 1;
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      n_cmp++;
      if ({in_ready, out_valid, bus.req_valid, out_misalign, out_timeout} !== 5'b10000 ||
          {out_rdata, bus.req_addr, bus.req_wmask} !== '0) begin
         n_err++;
         $display("FAIL rst_midop: in_ready=%b out_valid=%b req_valid=%b rdata=%h wmask=%h want 1 0 0 0 00",
                  in_ready, out_valid, bus.req_valid, out_rdata, bus.req_wmask);
      end
      in_valid = 1; in_op = 4'b1011; in_addr = 64'h8000_0010; in_wdata = 64'h0102_0304_0506_0708;
      bus.req_ready = 0;
      @(negedge clk);
      in_valid = 0;
      n_cmp++;
      if ({bus.req_valid, bus.req_we, bus.req_wmask} !== {2'b11, 8'hFF} ||
          bus.req_wdata !== 64'h0102_0304_0506_0708 || bus.req_addr !== 64'h8000_0010) begin
         n_err++;
         $display("FAIL sd_req: valid=%b we=%b wmask=%h addr=%h wdata=%h want 1 1 ff 80000010 0102030405060708",
                  bus.req_valid, bus.req_we, bus.req_wmask, bus.req_addr, bus.req_wdata);
      end
      bus.req_ready = 1;
      @(negedge clk);
      bus.resp_valid = 1;
      @(negedge clk);
      bus.resp_valid = 0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_rdata !== 64'h0) begin
         n_err++;
         $display("FAIL sd_ack: valid=%b rdata=%h want 1 0", out_valid, out_rdata);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
   endtask

   initial begin
      rst = 1; in_valid = 0; t_in_valid = 0; in_op = '0; in_addr = '0; in_wdata = '0;
      out_ready = 0;
      bus.req_ready = 0; bus.resp_valid = 0; bus.resp_rdata = '0;
      t_bus.req_ready = 0; t_bus.resp_valid = 0; t_bus.resp_rdata = '0;
      repeat (3) @(negedge clk);
      rst = 0;
      test_reset();
      test_lb();
      test_sh();
      test_misalign();
      test_stall();
      test_timeout();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
